// File: rtl/burst_weight_ram.sv
// Banked weight store with streaming burst reads: BURST_LEN single-port-read banks,
// unaligned bursts via per-bank row select + lane rotation, 2-entry output FIFO.

module burst_weight_bank #(
  parameter int WIDTH = 8,
  parameter int ROWS  = 16,
  parameter int RB    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [RB-1:0]    wr_row,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [RB-1:0]    rd_row,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [ROWS];

  // Read-first: the read samples mem before this edge's write lands.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_row] <= wr_data;
    if (rd_en) rd_data <= mem[rd_row];
  end
endmodule

module burst_weight_ram #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4,
  parameter int DEPTH     = 784*512,
  parameter int ADDR_BITS = $clog2(DEPTH),
  parameter int CNT_BITS  = $clog2(DEPTH/BURST_LEN+1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [ADDR_BITS-1:0]          wr_addr,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          rd_start,
  input  logic [ADDR_BITS-1:0]          rd_base,
  input  logic [CNT_BITS-1:0]           rd_count,
  output logic                          rd_busy,
  output logic                          rd_done,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BURST_LEN*WIDTH-1:0]    out_data,
  output logic [BURST_LEN-1:0]          out_mask,
  output logic                          out_last
);
  localparam int ROWS = DEPTH / BURST_LEN;
  localparam int RB   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LB   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  // Headroom so base + n*BURST_LEN + k never wraps, even past DEPTH.
  localparam int AW   = ADDR_BITS + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic                                last;
    logic [BURST_LEN-1:0]                mask;
    logic [BURST_LEN-1:0][WIDTH-1:0]     data;
  } beat_t;

  state_t state, state_nx;
  logic [AW-1:0]       cur;
  logic [CNT_BITS-1:0] left;
  logic [LB-1:0]       rot;
  logic                issue, pop, push;

  logic                fl_vld, fl_last;
  logic [LB-1:0]       fl_rot;
  logic [BURST_LEN-1:0] fl_mask;

  beat_t               fifo [2];
  beat_t               beat_in, head;
  logic                wp, rp;
  logic [1:0]          occ;

  logic [BURST_LEN-1:0][WIDTH-1:0] bank_q;
  logic [BURST_LEN-1:0][RB-1:0]    bank_row;
  logic [BURST_LEN-1:0]            bank_en, lane_ok;

  logic                wr_ok;
  logic [LB-1:0]       wr_bank;
  logic [RB-1:0]       wr_row;

  assign wr_ok   = AW'(wr_addr) < AW'(DEPTH);
  assign wr_bank = LB'(wr_addr % ADDR_BITS'(BURST_LEN));
  assign wr_row  = RB'(wr_addr / ADDR_BITS'(BURST_LEN));
  assign rot     = LB'(cur % AW'(BURST_LEN));

  assign rd_busy   = state != IDLE;
  assign out_valid = occ != 2'd0;
  assign head      = fifo[rp];
  assign pop       = out_valid && out_ready;
  assign push      = fl_vld;
  // The entry leaving this cycle frees a slot, which keeps one burst per cycle.
  assign issue     = (state == RUN) && (int'(occ) - int'(pop) + int'(fl_vld) < 2);

  assign out_data = out_valid ? head.data : '0;
  assign out_mask = out_valid ? head.mask : '0;
  assign out_last = out_valid ? head.last : 1'b0;

  for (genvar b = 0; b < BURST_LEN; b++) begin : g_bank
    logic [AW-1:0] a;
    // Bank b serves lane (b - rot) mod BURST_LEN of the current burst.
    always_comb a = cur + AW'((b + BURST_LEN - int'(rot)) % BURST_LEN);
    assign bank_en[b]  = issue && (a < AW'(DEPTH));
    assign bank_row[b] = RB'(a / AW'(BURST_LEN));
    assign lane_ok[b]  = (cur + AW'(b)) < AW'(DEPTH);

    burst_weight_bank #(.WIDTH(WIDTH), .ROWS(ROWS), .RB(RB)) u_bank (
      .clk     (clk),
      .wr_en   (wr_en && wr_ok && (wr_bank == LB'(b))),
      .wr_row  (wr_row),
      .wr_data (wr_data),
      .rd_en   (bank_en[b]),
      .rd_row  (bank_row[b]),
      .rd_data (bank_q[b])
    );
  end

  always_comb begin
    beat_in      = '0;
    beat_in.mask = fl_mask;
    beat_in.last = fl_last;
    for (int k = 0; k < BURST_LEN; k++)
      if (fl_mask[k]) beat_in.data[k] = bank_q[(int'(fl_rot) + k) % BURST_LEN];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (rd_start && rd_count != '0) state_nx = RUN;
      RUN:     if (issue && left == CNT_BITS'(1)) state_nx = DRAIN;
      DRAIN:   if (pop && head.last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_done <= 1'b0;
      cur     <= '0;
      left    <= '0;
      fl_vld  <= 1'b0;
      occ     <= '0;
      wp      <= 1'b0;
      rp      <= 1'b0;
    end else begin
      state   <= state_nx;
      rd_done <= (state == IDLE && rd_start && rd_count == '0) || (pop && head.last);
      if (state == IDLE && rd_start) begin
        cur  <= AW'(rd_base);
        left <= rd_count;
      end else if (issue) begin
        cur  <= cur + AW'(BURST_LEN);
        left <= left - CNT_BITS'(1);
      end
      fl_vld <= issue;
      if (issue) begin
        fl_rot  <= rot;
        fl_mask <= lane_ok;
        fl_last <= left == CNT_BITS'(1);
      end
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      occ <= occ + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk)
    if (push) fifo[wp] <= beat_in;
endmodule

// File: tb/tb_burst_weight_ram.sv
// Scoreboard bench for burst_weight_ram: word-addressed model, expected bursts queued at
// launch and compared on each output handshake.

module tb_burst_weight_ram;
  localparam int W = 8, BL = 4, D = 64, AB = 6, CB = 5;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  mask;
    logic        last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AB-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          rd_start = 1'b0;
  logic [AB-1:0] rd_base = '0;
  logic [CB-1:0] rd_count = '0;
  logic          rd_busy, rd_done, out_valid, out_last;
  logic          out_ready = 1'b1;
  logic [31:0]   out_data;
  logic [3:0]    out_mask;

  burst_weight_ram #(.WIDTH(W), .BURST_LEN(BL), .DEPTH(D), .ADDR_BITS(AB), .CNT_BITS(CB)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_start(rd_start), .rd_base(rd_base), .rd_count(rd_count), .rd_busy(rd_busy),
    .rd_done(rd_done), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mask(out_mask), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] model [D];
  beat_t      sb [$];
  int n_vec = 0, n_err = 0;
  int done_cnt = 0, done_cyc = -1, last_hs_cyc = -1;
  logic        prev_stall = 1'b0;
  logic [36:0] prev_out = '0;

  function automatic beat_t exp_beat(int base, int n, int cnt);
    beat_t e;
    e.data = '0; e.mask = '0; e.last = (n == cnt - 1);
    for (int k = 0; k < BL; k++) begin
      int a = base + n * BL + k;
      if (a < D) begin
        e.data[k*8 +: 8] = model[a];
        e.mask[k] = 1'b1;
      end
    end
    return e;
  endfunction

  // Output monitor: scoreboard pop on handshake, hold check while stalled.
  always @(negedge clk) begin
    beat_t e;
    if (rd_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (out_valid === 1'b1 && prev_stall) begin
      n_vec++;
      if ({out_last, out_mask, out_data} !== prev_out) begin
        n_err++;
        $display("FAIL stall_hold cyc=%0d got=%h want=%h", cyc, {out_last, out_mask, out_data}, prev_out);
      end
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat cyc=%0d got data=%h mask=%b last=%b want none", cyc, out_data, out_mask, out_last);
      end else begin
        e = sb.pop_front();
        if ({out_last, out_mask, out_data} !== {e.last, e.mask, e.data}) begin
          n_err++;
          $display("FAIL beat cyc=%0d got data=%h mask=%b last=%b want data=%h mask=%b last=%b",
                   cyc, out_data, out_mask, out_last, e.data, e.mask, e.last);
        end
      end
      last_hs_cyc = cyc;
    end
    prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
    prev_out   = {out_last, out_mask, out_data};
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (rd_busy !== 1'b0)   begin n_err++; $display("FAIL rst_busy got=%b want=0", rd_busy); end
    n_vec++; if (rd_done !== 1'b0)   begin n_err++; $display("FAIL rst_done got=%b want=0", rd_done); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b want=0", out_valid); end
    n_vec++; if (out_last !== 1'b0)  begin n_err++; $display("FAIL rst_last got=%b want=0", out_last); end
    n_vec++; if (out_data !== '0)    begin n_err++; $display("FAIL rst_data got=%h want=0", out_data); end
    n_vec++; if (out_mask !== '0)    begin n_err++; $display("FAIL rst_mask got=%b want=0", out_mask); end
  endtask

  task automatic test_preload();
    for (int i = 0; i < D; i++) begin
      step();
      wr_en = 1'b1; wr_addr = AB'(i); wr_data = 8'(i);
      model[i] = 8'(i);
    end
    step();
    wr_en = 1'b0;
  endtask

  // coll: write 0xAA to word 9 in the cycle the stream's first bank read is issued.
  task automatic run_stream(input int base, input int cnt, input bit toggle,
                            input bit inject, input bit coll, input string nm);
    int d0, s, t;
    for (int n = 0; n < cnt; n++) sb.push_back(exp_beat(base, n, cnt));
    if (coll) model[9] = 8'hAA;
    step();
    rd_start = 1'b1; rd_base = AB'(base); rd_count = CB'(cnt);
    d0 = done_cnt; s = cyc + 1;
    step();
    rd_start = 1'b0;
    if (coll) begin wr_en = 1'b1; wr_addr = AB'(9); wr_data = 8'hAA; end
    step();
    wr_en = 1'b0;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s early_valid cyc=%0d got=%b want=0", nm, cyc, out_valid); end
    step();
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1 || cyc != s + 2) begin
      n_err++; $display("FAIL %s first_valid cyc=%0d got=%b want=1 at %0d", nm, cyc, out_valid, s + 2);
    end
    t = 0;
    while (done_cnt == d0 && t < 200) begin
      step();
      if (toggle) out_ready = ~out_ready;
      if (inject) begin
        rd_start = (t == 1); rd_base = AB'(40); rd_count = CB'(2);
      end
      t++;
    end
    rd_start = 1'b0;
    out_ready = 1'b1;
    n_vec++; if (done_cnt != d0 + 1) begin n_err++; $display("FAIL %s done_seen got=%0d want=%0d", nm, done_cnt - d0, 1); end
    n_vec++; if (done_cyc != last_hs_cyc + 1) begin
      n_err++; $display("FAIL %s done_timing got=%0d want=%0d", nm, done_cyc, last_hs_cyc + 1);
    end
    if (!toggle) begin
      n_vec++; if (last_hs_cyc != s + 1 + cnt) begin
        n_err++; $display("FAIL %s throughput last_beat_cyc got=%0d want=%0d", nm, last_hs_cyc, s + 1 + cnt);
      end
    end
    repeat (6) step();
    n_vec++; if (done_cnt != d0 + 1) begin n_err++; $display("FAIL %s done_once got=%0d want=1", nm, done_cnt - d0); end
    n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL %s leftover got=%0d want=0", nm, sb.size()); end
    n_vec++; if (rd_busy !== 1'b0) begin n_err++; $display("FAIL %s busy_after got=%b want=0", nm, rd_busy); end
    sb.delete();
  endtask

  task automatic test_zero_count();
    int d0;
    step();
    rd_start = 1'b1; rd_base = '0; rd_count = '0;
    d0 = done_cnt;
    step();
    rd_start = 1'b0;
    @(negedge clk);
    n_vec++; if (rd_done !== 1'b1)   begin n_err++; $display("FAIL zero_done got=%b want=1", rd_done); end
    n_vec++; if (rd_busy !== 1'b0)   begin n_err++; $display("FAIL zero_busy got=%b want=0", rd_busy); end
    step();
    @(negedge clk);
    n_vec++; if (rd_done !== 1'b0)   begin n_err++; $display("FAIL zero_pulse got=%b want=0", rd_done); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL zero_valid got=%b want=0", out_valid); end
    repeat (4) step();
    n_vec++; if (done_cnt != d0 + 1) begin n_err++; $display("FAIL zero_done_once got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int d0;
    sb.push_back(exp_beat(0, 0, 8));
    sb.push_back(exp_beat(0, 1, 8));
    step();
    rd_start = 1'b1; rd_base = '0; rd_count = CB'(8);
    d0 = done_cnt;
    step();
    rd_start = 1'b0;
    repeat (4) step();
    out_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (rd_busy !== 1'b0)   begin n_err++; $display("FAIL midrst_busy got=%b want=0", rd_busy); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
    n_vec++; if (out_data !== '0)    begin n_err++; $display("FAIL midrst_data got=%h want=0", out_data); end
    n_vec++; if (sb.size() != 0)     begin n_err++; $display("FAIL midrst_beats left=%0d want=0", sb.size()); end
    out_ready = 1'b1;
    repeat (5) step();
    n_vec++; if (done_cnt != d0) begin n_err++; $display("FAIL midrst_no_done got=%0d want=0", done_cnt - d0); end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_preload();
    run_stream(0, 4, 1'b0, 1'b0, 1'b0, "aligned");
    run_stream(5, 2, 1'b0, 1'b0, 1'b0, "unaligned");
    run_stream(62, 1, 1'b0, 1'b0, 1'b0, "tail");
    run_stream(0, 8, 1'b1, 1'b0, 1'b0, "backpressure");
    test_reset_mid();
    run_stream(0, 2, 1'b0, 1'b0, 1'b0, "after_reset");
    test_zero_count();
    run_stream(0, 4, 1'b0, 1'b1, 1'b0, "ignore_start");
    run_stream(8, 1, 1'b0, 1'b0, 1'b1, "collision");
    run_stream(8, 1, 1'b0, 1'b0, 1'b0, "after_write");
    run_stream(58, 3, 1'b1, 1'b0, 1'b0, "tail_stall");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/burst_weight_ram.md
BURST_WEIGHT_RAM -- requirements
Module: burst_weight_ram

Interface
REQ-001 Parameter WIDTH, default 8: bits per stored weight word.
REQ-002 Parameter BURST_LEN, default 4: words per burst; power of two, 1..16; one memory bank per lane.
REQ-003 Parameter DEPTH, default 784*512: total words; integer multiple of BURST_LEN.
REQ-004 Parameter ADDR_BITS, default $clog2(DEPTH): word-address width.
REQ-005 Parameter CNT_BITS, default $clog2(DEPTH/BURST_LEN+1): burst-count width.
REQ-006 The block SHALL have one clock, clk, and a synchronous active-high reset, rst.
REQ-007 clk  in  1  rising-edge clock for all state.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 wr_en  in  1  writes wr_data to wr_addr this edge.
REQ-010 wr_addr  in  ADDR_BITS  word address; wr_addr >= DEPTH is ignored.
REQ-011 wr_data  in  WIDTH  word to store.
REQ-012 rd_start  in  1  launches a stream; sampled only in IDLE.
REQ-013 rd_base  in  ADDR_BITS  first word address, any alignment.
REQ-014 rd_count  in  CNT_BITS  number of bursts in the stream.
REQ-015 rd_busy  out  1  high in RUN and DRAIN.
REQ-016 rd_done  out  1  one-cycle pulse at stream completion.
REQ-017 out_valid  out  1  out_data, out_mask and out_last are valid.
REQ-018 out_ready  in  1  consumer accepts the burst when high with out_valid.
REQ-019 out_data  out  BURST_LEN*WIDTH  lane k at bits [(k+1)*WIDTH-1 : k*WIDTH].
REQ-020 out_mask  out  BURST_LEN  bit k is 1 when lane k holds an in-range word.
REQ-021 out_last  out  1  marks the final burst of the stream.

Function
REQ-022 Storage SHALL be BURST_LEN banks of depth DEPTH/BURST_LEN; word a lives in bank a%BURST_LEN at row a/BURST_LEN.
REQ-023 Burst n of a stream SHALL return words rd_base+n*BURST_LEN+k in lane k, with per-bank row selection and lane rotation so that unaligned bases cost no extra cycles.
REQ-024 Lanes whose word address is >= DEPTH SHALL output zero with the out_mask bit cleared; addresses do not wrap.
REQ-025 FSM states: IDLE, RUN (issuing bank reads), DRAIN (all reads issued, output not yet empty).
REQ-026 IDLE -> RUN on rd_start with rd_count > 0; rd_start with rd_count = 0 SHALL pulse rd_done on the next cycle, stay IDLE and produce no output.
REQ-027 rd_start while rd_busy is high SHALL be ignored.
REQ-028 Bank read latency SHALL be one cycle; output is held in a 2-entry FIFO, and a read is issued only when FIFO occupancy plus reads in flight is < 2.
REQ-029 With out_ready held high, the first out_valid SHALL occur 2 cycles after the rd_start edge, and one burst SHALL be delivered per cycle thereafter.
REQ-030 While out_valid=1 and out_ready=0, out_data, out_mask and out_last SHALL hold stable; no burst is dropped or duplicated.
REQ-031 RUN -> DRAIN after the last read is issued; DRAIN -> IDLE on the handshake of the out_last burst; rd_done SHALL pulse in the cycle after that handshake.
REQ-032 A write and a read of the same word in the same cycle SHALL return the old data (read-first); the write takes effect for later reads.
REQ-033 Writes SHALL be accepted in every state, including during a stream.

Reset
REQ-034 During rst: FSM to IDLE, FIFO and in-flight reads flushed, burst counter cleared; from the next cycle rd_busy=0, rd_done=0, out_valid=0, out_last=0, out_data=0, out_mask=0.
REQ-035 Reset SHALL NOT clear bank contents; reset mid-stream abandons the stream without a rd_done pulse.

Verification (WIDTH=8, BURST_LEN=4, DEPTH=64, mem[i]=i preloaded via the write port)
REQ-036 rd_base=0, rd_count=4, out_ready=1 -> out_data 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on consecutive cycles starting at the rd_start edge +2; out_last on the 4th burst; rd_done one cycle later.
REQ-037 rd_base=5, rd_count=2 -> out_data 0x08070605 then 0x0C0B0A09, out_mask 4'b1111.
REQ-038 rd_base=62, rd_count=1 -> out_data 0x00003F3E, out_mask 4'b0011, out_last=1.
REQ-039 rd_base=0, rd_count=8, out_ready toggling 1,0,1,0 -> 8 bursts in order, outputs stable while stalled, rd_done exactly once.
REQ-040 rst asserted after 2 bursts of an 8-burst stream -> next cycle rd_busy=0 and out_valid=0, no rd_done; a new stream from rd_base=0 then returns 0x03020100 first.
REQ-041 rd_count=0 -> rd_done pulse, no out_valid; rd_start during an active stream is ignored; a write of 0xAA to address 9, issued in the same cycle as the bank read of 9 in stream rd_base=8, returns 0x09 in that burst and 0xAA in a later stream.
